// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - round-robin multi-phase traffic light controller with walk service and programmable interval timer
// Optional feature macro: SKIP_EMPTY_EN (skip approaches without demand when leaving all-red)
module traffic_phase_controller #(
    parameter int NUM_PHASES = 4,
    parameter int TIMER_W    = 8,
    parameter int T_BASE     = 6,
    parameter int T_EXT      = 3,
    parameter int T_YEL      = 2,
    parameter int T_ALLRED   = 1,
    localparam int PHASE_W   = $clog2(NUM_PHASES)
) (
    input  logic                  clock,
    input  logic                  reset_sync,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] sensor_sync,
    input  logic                  walk_req,
    input  logic                  prog_sync,
    input  logic                  prog_we,
    input  logic [1:0]            prog_sel,
    input  logic [TIMER_W-1:0]    prog_value,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic                  walk,
    output logic                  wr_reset,
    output logic [PHASE_W-1:0]    active_phase,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_GREEN_BASE = 3'd0,
        S_GREEN_EXT  = 3'd1,
        S_YELLOW     = 3'd2,
        S_WALK       = 3'd3,
        S_ALL_RED    = 3'd4
    } state_t;

    localparam logic [NUM_PHASES-1:0] PHASE0_MASK = NUM_PHASES'(1);

    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d, next_phase;
    logic [TIMER_W-1:0]    count_q, count_d;
    logic [TIMER_W-1:0]    dur_base, dur_ext, dur_yel, dur_allred;
    logic                  pend_q, pend_d;
    logic                  expired;
    logic [NUM_PHASES-1:0] lamp_onehot, green_d, yellow_d;

    // A programmed duration of zero still lasts one tick
    function automatic logic [TIMER_W-1:0] clamp_dur(input logic [TIMER_W-1:0] d);
        return (d == '0) ? TIMER_W'(1) : d;
    endfunction

    // Countdown value loaded on the edge that enters state s
    function automatic logic [TIMER_W-1:0] dur_for(input state_t s,
                                                    input logic [TIMER_W-1:0] b,
                                                    input logic [TIMER_W-1:0] e,
                                                    input logic [TIMER_W-1:0] y,
                                                    input logic [TIMER_W-1:0] a);
        case (s)
            S_GREEN_BASE:       return clamp_dur(b);
            S_GREEN_EXT,
            S_WALK:             return clamp_dur(e);
            S_YELLOW:           return clamp_dur(y);
            default:            return clamp_dur(a);
        endcase
    endfunction

`ifdef SKIP_EMPTY_EN
    logic found;
    int   idx;

    // Next phase with demand in round-robin order; phase 0 is served whenever the search reaches it
    always_comb begin
        next_phase = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i < NUM_PHASES; i++) begin
            idx = (int'(phase_q) + i) % NUM_PHASES;
            if (!found) begin
                if (idx == 0) begin
                    found = 1'b1;
                end else if (sensor_sync[idx]) begin
                    next_phase = PHASE_W'(idx);
                    found      = 1'b1;
                end
            end
        end
    end
`else
    // Next phase in strict round-robin order, wrapping at the last approach
    always_comb begin
        next_phase = (phase_q == PHASE_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
    end
`endif

    // Next-state, countdown and walk-latch logic; lamps decoded from the next state
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        pend_d  = pend_q;
        expired = tick && (count_q <= TIMER_W'(1));

        if (walk_req && (state_q != S_WALK)) begin
            pend_d = 1'b1;
        end

        if (prog_sync) begin
            state_d = S_GREEN_BASE;
            phase_d = '0;
            count_d = clamp_dur(dur_base);
        end else if (expired) begin
            case (state_q)
                S_GREEN_BASE: state_d = sensor_sync[phase_q] ? S_GREEN_EXT : S_YELLOW;
                S_GREEN_EXT:  state_d = S_YELLOW;
                S_YELLOW:     state_d = pend_q ? S_WALK : S_ALL_RED;
                S_WALK:       state_d = S_ALL_RED;
                default: begin
                    state_d = S_GREEN_BASE;
                    phase_d = next_phase;
                end
            endcase
            count_d = dur_for(state_d, dur_base, dur_ext, dur_yel, dur_allred);
            if (state_d == S_WALK) begin
                pend_d = 1'b0;
            end
        end else if (tick) begin
            count_d = count_q - 1'b1;
        end

        lamp_onehot = PHASE0_MASK << phase_d;
        green_d     = ((state_d == S_GREEN_BASE) || (state_d == S_GREEN_EXT)) ? lamp_onehot : '0;
        yellow_d    = (state_d == S_YELLOW) ? lamp_onehot : '0;
    end

    // State, countdown, walk latch and registered lamp outputs
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            state_q  <= S_GREEN_BASE;
            phase_q  <= '0;
            count_q  <= clamp_dur(TIMER_W'(T_BASE));
            pend_q   <= 1'b0;
            green    <= PHASE0_MASK;
            yellow   <= '0;
            red      <= ~PHASE0_MASK;
            walk     <= 1'b0;
            wr_reset <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            green    <= green_d;
            yellow   <= yellow_d;
            red      <= ~(green_d | yellow_d);
            walk     <= (state_d == S_WALK);
            wr_reset <= (state_d == S_WALK);
        end
    end

    // Runtime-programmable duration registers, writable only in program mode
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            dur_base   <= TIMER_W'(T_BASE);
            dur_ext    <= TIMER_W'(T_EXT);
            dur_yel    <= TIMER_W'(T_YEL);
            dur_allred <= TIMER_W'(T_ALLRED);
        end else if (prog_sync && prog_we) begin
            case (prog_sel)
                2'd0:    dur_base   <= prog_value;
                2'd1:    dur_ext    <= prog_value;
                2'd2:    dur_yel    <= prog_value;
                default: dur_allred <= prog_value;
            endcase
        end
    end

    assign state        = state_q;
    assign active_phase = phase_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - self-checking bench for traffic_phase_controller
module tb_traffic_phase_controller;

    logic       clock = 1'b0;
    logic       reset_sync = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] sensor_sync = '0;
    logic       walk_req = 1'b0;
    logic       prog_sync = 1'b0;
    logic       prog_we = 1'b0;
    logic [1:0] prog_sel = '0;
    logic [7:0] prog_value = '0;
    logic [3:0] green, yellow, red;
    logic       walk, wr_reset;
    logic [1:0] active_phase;
    logic [2:0] state;

    traffic_phase_controller #(
        .NUM_PHASES(4), .TIMER_W(8), .T_BASE(6), .T_EXT(3), .T_YEL(2), .T_ALLRED(1)
    ) dut (
        .clock(clock), .reset_sync(reset_sync), .tick(tick), .sensor_sync(sensor_sync),
        .walk_req(walk_req), .prog_sync(prog_sync), .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_value(prog_value), .green(green), .yellow(yellow), .red(red), .walk(walk),
        .wr_reset(wr_reset), .active_phase(active_phase), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] ph;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic       w;
        logic       wr;
    } exp_t;

    typedef struct {
        logic       r, p, we;
        logic [1:0] sel;
        logic [7:0] val;
        logic       tk;
        logic [3:0] sn;
        logic       wq;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [2:0] cur_st;
    logic [1:0] cur_ph;
    logic [3:0] cur_g, cur_y;
    logic       cur_w;

    // Reference model: counts elapsed ticks against a limit locked when a state is entered
    int m_st = 0, m_ph = 0, m_el = 0, m_lim = 6;
    int m_dur[4] = '{6, 3, 2, 1};
    bit m_pend = 0;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int dur_of(input int s);
        case (s)
            0:       return m_dur[0];
            1, 3:    return m_dur[1];
            2:       return m_dur[2];
            default: return m_dur[3];
        endcase
    endfunction

    function automatic int model_next_phase(input logic [3:0] sn);
`ifdef SKIP_EMPTY_EN
        for (int i = 1; i < 4; i++) begin
            int c;
            c = (m_ph + i) % 4;
            if (c == 0) return 0;
            if (sn[c]) return c;
        end
        return 0;
`else
        return (m_ph + 1) % 4;
`endif
    endfunction

    function automatic void model_step(input logic r, p, we, input logic [1:0] sel,
                                       input logic [7:0] val, input logic tk,
                                       input logic [3:0] sn, input logic wq);
        bit np;
        if (r) begin
            m_st = 0; m_ph = 0; m_el = 0; m_pend = 0;
            m_dur = '{6, 3, 2, 1};
            m_lim = 6;
            return;
        end
        np = m_pend || (wq && m_st != 3);
        if (p) begin
            m_lim = eff(m_dur[0]);
            if (we) m_dur[sel] = int'(val);
            m_st = 0; m_ph = 0; m_el = 0;
        end else if (tk) begin
            m_el++;
            if (m_el >= m_lim) begin
                m_el = 0;
                case (m_st)
                    0: m_st = sn[m_ph] ? 1 : 2;
                    1: m_st = 2;
                    2: m_st = m_pend ? 3 : 4;
                    3: m_st = 4;
                    default: begin
                        m_ph = model_next_phase(sn);
                        m_st = 0;
                    end
                endcase
                if (m_st == 3) np = 0;
                m_lim = eff(dur_of(m_st));
            end
        end
        m_pend = np;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st = 3'(m_st);
        e.ph = 2'(m_ph);
        for (int q = 0; q < 4; q++) begin
            e.g[q] = (m_st <= 1) && (m_ph == q);
            e.y[q] = (m_st == 2) && (m_ph == q);
            e.r[q] = !(e.g[q] || e.y[q]);
        end
        e.w  = (m_st == 3);
        e.wr = (m_st == 3);
        return e;
    endfunction

    function automatic exp_t mkexp(input logic [2:0] st, input logic [1:0] ph,
                                   input logic [3:0] g, input logic [3:0] y, input logic w);
        exp_t e;
        e.st = st; e.ph = ph; e.g = g; e.y = y; e.r = ~(g | y); e.w = w; e.wr = w;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of inputs, push the expectation, compare after the edge
    task automatic drive(input logic r, p, we, input logic [1:0] sel, input logic [7:0] val,
                         input logic tk, input logic [3:0] sn, input logic wq,
                         input bit use_tbl, input exp_t te);
        exp_t e, a;
        reset_sync = r; prog_sync = p; prog_we = we; prog_sel = sel; prog_value = val;
        tick = tk; sensor_sync = sn; walk_req = wq;
        model_step(r, p, we, sel, val, tk, sn, wq);
        exp_q.push_back(use_tbl ? te : model_out());
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        a = '{st: state, ph: active_phase, g: green, y: yellow, r: red, w: walk, wr: wr_reset};
        check(use_tbl ? "table_outputs" : "model_outputs", 32'(a), 32'(e));
        cur_st = state; cur_ph = active_phase; cur_g = green; cur_y = yellow; cur_w = walk;
    endtask

    task automatic step(input logic tk, input logic [3:0] sn, input logic wq);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, tk, sn, wq, 1'b0, '0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 4'd0, 1'b0, 1'b0, '0);
    endtask

    // Number of cycles the current lamp pattern persists (including the current cycle)
    task automatic measure(input int period, input logic [3:0] sn, input logic wq, output int n);
        logic [8:0] snap;
        snap = {cur_g, cur_y, cur_w};
        n = 1;
        for (int i = 0; i < 200; i++) begin
            step(((i % period) == period - 1), sn, wq);
            if ({cur_g, cur_y, cur_w} != snap) return;
            n++;
        end
        n = -1;
    endtask

    vec_t tbl[18];
    int   n, total;

    initial begin
        // Reset, tick-driven timing, hold on tick=0, programming and reset restore
        tbl[0] = '{1, 0, 0, 0, 0, 1, 0, 0, mkexp(0, 0, 4'b0001, 0, 0)};
        for (int i = 1; i <= 5; i++) tbl[i] = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(0, 0, 4'b0001, 0, 0)};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(2, 0, 0, 4'b0001, 0)};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(2, 0, 0, 4'b0001, 0)};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(4, 0, 0, 0, 0)};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(0, 1, 4'b0010, 0, 0)};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, mkexp(0, 1, 4'b0010, 0, 0)};
        tbl[11] = '{0, 1, 1, 0, 2, 1, 0, 0, mkexp(0, 0, 4'b0001, 0, 0)};
        tbl[12] = '{0, 1, 1, 2, 0, 1, 0, 0, mkexp(0, 0, 4'b0001, 0, 0)};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(0, 0, 4'b0001, 0, 0)};
        tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(2, 0, 0, 4'b0001, 0)};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(4, 0, 0, 0, 0)};
        tbl[16] = '{0, 0, 0, 0, 0, 1, 0, 0, mkexp(0, 1, 4'b0010, 0, 0)};
        tbl[17] = '{1, 0, 0, 0, 0, 1, 0, 0, mkexp(0, 0, 4'b0001, 0, 0)};

        @(negedge clock);
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r, tbl[i].p, tbl[i].we, tbl[i].sel, tbl[i].val, tbl[i].tk,
                  tbl[i].sn, tbl[i].wq, 1'b1, tbl[i].e);
        end
        measure(1, 4'd0, 1'b0, n);
        check("green_after_reset_restore", n, 6);

        // Full lap with no demand: 4 x (6 + 2 + 1) cycles, back to phase 0
        do_reset();
        total = 0;
        for (int ph = 0; ph < 4; ph++) begin
            measure(1, 4'd0, 1'b0, n); check("lap_green", n, 6);  total += n;
            measure(1, 4'd0, 1'b0, n); check("lap_yellow", n, 2); total += n;
            measure(1, 4'd0, 1'b0, n); check("lap_allred", n, 1); total += n;
        end
        check("lap_len", total, 36);
        check("lap_back_phase0", {cur_st, cur_ph, cur_g}, {3'd0, 2'd0, 4'b0001});

        // Demand on phase 0 grants one extension; phase 1 gets base green only
        do_reset();
        measure(1, 4'b0001, 1'b0, n); check("ext_green", n, 9);
        measure(1, 4'b0001, 1'b0, n); check("ext_yellow", n, 2);
        measure(1, 4'b0001, 1'b0, n); check("ext_allred", n, 1);
        measure(1, 4'b0001, 1'b0, n); check("ext_next_green", n, 6);

        // Walk request during phase 1 green, second request during WALK is absorbed
        do_reset();
        for (int k = 0; k < 3; k++) measure(1, 4'd0, 1'b0, n);
        check("walk_phase1_green", {cur_ph, cur_g}, {2'd1, 4'b0010});
        step(1'b1, 4'd0, 1'b1);
        measure(1, 4'd0, 1'b0, n); check("walk_green_rest", n, 5);
        measure(1, 4'd0, 1'b0, n); check("walk_yellow", n, 2);
        check("walk_entered", {cur_st, cur_w, cur_g, cur_y}, {3'd3, 1'b1, 4'd0, 4'd0});
        measure(1, 4'd0, 1'b1, n); check("walk_len", n, 3);
        measure(1, 4'd0, 1'b0, n); check("walk_allred", n, 1);
        check("walk_then_green2", {cur_ph, cur_g}, {2'd2, 4'b0100});
        measure(1, 4'd0, 1'b0, n); check("green2", n, 6);
        measure(1, 4'd0, 1'b0, n); check("yellow2", n, 2);
        check("no_second_walk", cur_st, 3'd4);

        // Sparse ticks: every 4th cycle
        do_reset();
        measure(4, 4'd0, 1'b0, n); check("sparse_tick_green", n, 24);

`ifdef SKIP_EMPTY_EN
        do_reset();
        measure(1, 4'b1000, 1'b0, n); check("skip_green0", n, 6);
        measure(1, 4'b1000, 1'b0, n); check("skip_yellow0", n, 2);
        measure(1, 4'b1000, 1'b0, n); check("skip_allred0", n, 1);
        check("skip_to_phase3", {cur_ph, cur_g}, {2'd3, 4'b1000});
        measure(1, 4'b1000, 1'b0, n); check("skip_green3", n, 9);
        measure(1, 4'b1000, 1'b0, n); check("skip_yellow3", n, 2);
        measure(1, 4'b1000, 1'b0, n); check("skip_allred3", n, 1);
        check("skip_back_phase0", {cur_ph, cur_g}, {2'd0, 4'b0001});
`endif

        // Randomised traffic with occasional programming and resets, checked by the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0), 1'($urandom),
                  2'($urandom), 8'($urandom_range(0, 4)), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 19) == 0), 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
